// File: rtl/wb_register_file_pkg.sv
// Shared constants for the write-back register file and its pending-write scoreboard.
// Register index 0 is hardwired: never stored, never tracked.
package wb_register_file_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_PEND_W = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_register_file_if.sv
// WB-stage write port plus ID-stage read/issue port of the register file.
// The master side is the pipeline, the slave side is the register file.
interface wb_register_file_if
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic              RegWriteSignal;
  logic [ADDR_W-1:0] ReadAddrA;
  logic [ADDR_W-1:0] ReadAddrB;
  logic              UseA;
  logic              UseB;
  logic              IssueValid;
  logic              IssueWritesReg;
  logic [ADDR_W-1:0] IssueDest;
  logic [DATA_W-1:0] ReadDataA;
  logic [DATA_W-1:0] ReadDataB;
  logic              Stall;
  logic              RetireUnderflow;

  modport master (
    output WriteAddr, WriteData, RegWriteSignal,
    output ReadAddrA, ReadAddrB, UseA, UseB,
    output IssueValid, IssueWritesReg, IssueDest,
    input  ReadDataA, ReadDataB, Stall, RetireUnderflow
  );

  modport slave (
    input  WriteAddr, WriteData, RegWriteSignal,
    input  ReadAddrA, ReadAddrB, UseA, UseB,
    input  IssueValid, IssueWritesReg, IssueDest,
    output ReadDataA, ReadDataB, Stall, RetireUnderflow
  );
endinterface

// File: rtl/wb_pending_scoreboard.sv
// Per-register pending-write counters; combinational stall (RAW hazard or counter saturation).
// Counters and the sticky underflow flag update on the clock edge; a same-cycle retire lifts the stall.
module wb_pending_scoreboard
  import wb_register_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_vld,
  input  logic              issue_writes_reg,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              ret_vld,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              use_a,
  input  logic              use_b,
  output logic              stall,
  output logic              underflow
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic              underflow_q;
  logic              underflow_d;

  logic              ret_live;
  logic              issue_live;
  logic              hazard_a;
  logic              hazard_b;
  logic              saturate;
  logic              accept;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;

  // A source whose only outstanding write retires this cycle is served by the bypass.
  always_comb begin
    ret_live   = ret_vld && (ret_addr != ZERO);
    issue_live = issue_writes_reg && (issue_dest != ZERO);
    hazard_a   = use_a && (rd_addr_a != ZERO) && (pend_q[rd_addr_a] != '0)
                 && !(ret_live && (ret_addr == rd_addr_a) && (pend_q[rd_addr_a] == PEND_ONE));
    hazard_b   = use_b && (rd_addr_b != ZERO) && (pend_q[rd_addr_b] != '0)
                 && !(ret_live && (ret_addr == rd_addr_b) && (pend_q[rd_addr_b] == PEND_ONE));
    saturate   = issue_live && (pend_q[issue_dest] == PEND_MAX)
                 && !(ret_live && (ret_addr == issue_dest));
    stall      = issue_vld && (hazard_a || hazard_b || saturate);
    accept     = issue_vld && !stall && issue_live;
    inc_vec    = '0;
    dec_vec    = '0;
    if (accept)   inc_vec[issue_dest] = 1'b1;
    if (ret_live) dec_vec[ret_addr]   = 1'b1;
  end

  always_comb begin
    pend_d      = pend_q;
    underflow_d = underflow_q;
    for (int r = 1; r < NREG; r++) begin
      if (dec_vec[r] && (pend_q[r] == '0)) underflow_d = 1'b1;
      case ({inc_vec[r], dec_vec[r]})
        2'b10:   pend_d[r] = pend_q[r] + PEND_ONE;
        2'b01:   if (pend_q[r] != '0) pend_d[r] = pend_q[r] - PEND_ONE;
        default: pend_d[r] = pend_q[r];
      endcase
    end
    pend_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
      underflow_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;
endmodule

// File: rtl/wb_register_file.sv
// 32x32 register file: 1-edge write from WB, combinational reads with same-cycle write bypass.
// ID is held via Stall from the pending-write scoreboard; the WB side is never back-pressured.
module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              ClockInput,
  input  logic              ResetInputN,
  wb_register_file_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic              wr_live;

  assign wr_live = bus.RegWriteSignal && (bus.WriteAddr != ZERO);

  always_comb begin
    mem_d = mem_q;
    if (wr_live) mem_d[bus.WriteAddr] = bus.WriteData;
  end

  always_ff @(posedge ClockInput or negedge ResetInputN) begin
    if (!ResetInputN) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Entry 0 is never written, so the plain array read already returns 0 for it.
  assign bus.ReadDataA = (wr_live && (bus.WriteAddr == bus.ReadAddrA)) ? bus.WriteData
                                                                       : mem_q[bus.ReadAddrA];
  assign bus.ReadDataB = (wr_live && (bus.WriteAddr == bus.ReadAddrB)) ? bus.WriteData
                                                                       : mem_q[bus.ReadAddrB];

  wb_pending_scoreboard #(
    .ADDR_W (ADDR_W),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk              (ClockInput),
    .rst_n            (ResetInputN),
    .issue_vld        (bus.IssueValid),
    .issue_writes_reg (bus.IssueWritesReg),
    .issue_dest       (bus.IssueDest),
    .ret_vld          (bus.RegWriteSignal),
    .ret_addr         (bus.WriteAddr),
    .rd_addr_a        (bus.ReadAddrA),
    .rd_addr_b        (bus.ReadAddrB),
    .use_a            (bus.UseA),
    .use_b            (bus.UseB),
    .stall            (bus.Stall),
    .underflow        (bus.RetireUnderflow)
  );
endmodule

// File: tb/tb_wb_register_file.sv
// Directed scenarios for wb_register_file; expected outputs are queued as stimulus is
// driven and compared once the combinational outputs settle, away from the clock edge.
module tb_wb_register_file;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_register_file_if bus ();

  wb_register_file dut (
    .ClockInput  (clk),
    .ResetInputN (rst_n),
    .bus         (bus)
  );

  typedef enum int {OBS_RDA, OBS_RDB, OBS_STALL, OBS_UF} obs_e;
  typedef struct {
    string       tag;
    obs_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] observe(input obs_e sel);
    case (sel)
      OBS_RDA:   return bus.ReadDataA;
      OBS_RDB:   return bus.ReadDataB;
      OBS_STALL: return {31'd0, bus.Stall};
      default:   return {31'd0, bus.RetireUnderflow};
    endcase
  endfunction

  task automatic expect_out(input string tag, input obs_e sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic settle_check();
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.WriteAddr      = '0;
    bus.WriteData      = '0;
    bus.RegWriteSignal = 1'b0;
    bus.ReadAddrA      = '0;
    bus.ReadAddrB      = '0;
    bus.UseA           = 1'b0;
    bus.UseB           = 1'b0;
    bus.IssueValid     = 1'b0;
    bus.IssueWritesReg = 1'b0;
    bus.IssueDest      = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Out of reset
    bus.ReadAddrA = 5'd5;
    bus.ReadAddrB = 5'd0;
    expect_out("rst_rda", OBS_RDA, 32'd0);
    expect_out("rst_rdb", OBS_RDB, 32'd0);
    expect_out("rst_stall", OBS_STALL, 32'd0);
    expect_out("rst_uf", OBS_UF, 32'd0);
    settle_check();
    next_cycle();

    // Register 0: write and issue are both no-ops
    idle();
    bus.RegWriteSignal = 1'b1;
    bus.WriteAddr      = 5'd0;
    bus.WriteData      = 32'h1234_5678;
    bus.IssueValid     = 1'b1;
    bus.IssueWritesReg = 1'b1;
    bus.IssueDest      = 5'd0;
    bus.UseA           = 1'b1;
    bus.ReadAddrA      = 5'd0;
    expect_out("r0_bypass", OBS_RDA, 32'd0);
    expect_out("r0_stall_wr", OBS_STALL, 32'd0);
    settle_check();
    next_cycle();

    idle();
    bus.IssueValid = 1'b1;
    bus.UseA = 1'b1;
    bus.UseB = 1'b1;
    expect_out("r0_rda", OBS_RDA, 32'd0);
    expect_out("r0_rdb", OBS_RDB, 32'd0);
    expect_out("r0_stall_rd", OBS_STALL, 32'd0);
    expect_out("r0_uf", OBS_UF, 32'd0);
    settle_check();
    next_cycle();

    // RAW hazard on r3
    idle();
    bus.IssueValid     = 1'b1;
    bus.IssueWritesReg = 1'b1;
    bus.IssueDest      = 5'd3;
    expect_out("raw_issue", OBS_STALL, 32'd0);
    settle_check();
    next_cycle();

    for (int i = 0; i < 3; i++) begin
      idle();
      bus.IssueValid = 1'b1;
      bus.UseA       = 1'b1;
      bus.ReadAddrA  = 5'd3;
      expect_out($sformatf("raw_hold%0d", i), OBS_STALL, 32'd1);
      settle_check();
      next_cycle();
    end

    bus.RegWriteSignal = 1'b1;
    bus.WriteAddr      = 5'd3;
    bus.WriteData      = 32'hCAFE_F00D;
    expect_out("raw_release", OBS_STALL, 32'd0);
    expect_out("raw_bypass", OBS_RDA, 32'hCAFE_F00D);
    settle_check();
    next_cycle();

    idle();
    bus.IssueValid = 1'b1;
    bus.UseB       = 1'b1;
    bus.ReadAddrB  = 5'd3;
    expect_out("raw_after_stall", OBS_STALL, 32'd0);
    expect_out("raw_after_rdb", OBS_RDB, 32'hCAFE_F00D);
    expect_out("raw_uf", OBS_UF, 32'd0);
    settle_check();
    next_cycle();

    // Saturation of r9 at three in flight
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.IssueValid     = 1'b1;
      bus.IssueWritesReg = 1'b1;
      bus.IssueDest      = 5'd9;
      expect_out($sformatf("sat_fill%0d", i), OBS_STALL, 32'd0);
      settle_check();
      next_cycle();
    end

    expect_out("sat_full", OBS_STALL, 32'd1);
    settle_check();
    next_cycle();

    bus.RegWriteSignal = 1'b1;
    bus.WriteAddr      = 5'd9;
    bus.WriteData      = 32'h0000_0055;
    expect_out("sat_retire", OBS_STALL, 32'd0);
    settle_check();
    next_cycle();

    bus.RegWriteSignal = 1'b0;
    expect_out("sat_still_full", OBS_STALL, 32'd1);
    expect_out("sat_uf", OBS_UF, 32'd0);
    settle_check();
    next_cycle();

    // Write/bypass on r7 with nothing pending -> underflow
    idle();
    bus.RegWriteSignal = 1'b1;
    bus.WriteAddr      = 5'd7;
    bus.WriteData      = 32'hDEAD_BEEF;
    bus.ReadAddrA      = 5'd7;
    bus.ReadAddrB      = 5'd7;
    expect_out("wr_bypass_a", OBS_RDA, 32'hDEAD_BEEF);
    expect_out("wr_bypass_b", OBS_RDB, 32'hDEAD_BEEF);
    expect_out("uf_before_edge", OBS_UF, 32'd0);
    settle_check();
    next_cycle();

    bus.RegWriteSignal = 1'b0;
    bus.WriteData      = 32'h0;
    expect_out("wr_stored", OBS_RDA, 32'hDEAD_BEEF);
    expect_out("uf_set", OBS_UF, 32'd1);
    settle_check();
    next_cycle();

    expect_out("uf_held", OBS_UF, 32'd1);
    settle_check();

    // Asynchronous reset mid-cycle discards data, pending counts and the flag
    bus.IssueValid     = 1'b1;
    bus.IssueWritesReg = 1'b1;
    bus.IssueDest      = 5'd9;
    bus.UseB           = 1'b1;
    bus.ReadAddrB      = 5'd9;
    rst_n = 1'b0;
    expect_out("arst_uf", OBS_UF, 32'd0);
    expect_out("arst_rda", OBS_RDA, 32'd0);
    expect_out("arst_stall", OBS_STALL, 32'd0);
    settle_check();
    next_cycle();

    rst_n = 1'b1;
    expect_out("post_rst_stall", OBS_STALL, 32'd0);
    expect_out("post_rst_rdb", OBS_RDB, 32'd0);
    settle_check();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
